// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared writeback types and sizing for the writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int REG_WIDTH    = 5;
    localparam int DIV_WB_DEPTH = 2;

    typedef struct packed {
        logic                 instruction_valid;
        logic                 register_write;
        logic [REG_WIDTH-1:0] rd;
        logic [31:0]          exe_result;
    } exe_wb_inf_t;

    typedef struct packed {
        logic [REG_WIDTH-1:0] rd;
        logic [31:0]          data;
    } div_entry_t;

endpackage : wb_arbiter_pkg
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_if
// Description : Execute-to-register-file writeback bundle with core controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                 stall;
    logic                 flush;
    exe_wb_inf_t          pipe_wb_inf;
    exe_wb_inf_t          div_wb_inf;
    logic                 rf_we;
    logic [REG_WIDTH-1:0] rf_rd;
    logic [31:0]          rf_wdata;
    logic                 div_wb_full;
    logic                 div_wb_overflow;

    modport master (
        output stall, flush, pipe_wb_inf, div_wb_inf,
        input  rf_we, rf_rd, rf_wdata, div_wb_full, div_wb_overflow
    );

    modport slave (
        input  stall, flush, pipe_wb_inf, div_wb_inf,
        output rf_we, rf_rd, rf_wdata, div_wb_full, div_wb_overflow
    );

endinterface : wb_arbiter_if
`default_nettype wire

// File: rtl/wb_arbiter_div_result_queue.sv
`default_nettype none
// ============================================================================
// Module      : div_result_queue
// Description : Circular buffer of divider results with per-entry valid bits
//               and an rd compare-and-kill port.
// Revision    : 1.0 - initial release
// ============================================================================
module div_result_queue
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = DIV_WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_enq,
    input  div_entry_t           i_enq_data,
    input  logic                 i_deq,
    input  logic                 i_kill,
    input  logic [REG_WIDTH-1:0] i_kill_rd,
    output logic                 o_head_valid,
    output div_entry_t           o_head_data,
    output logic                 o_empty,
    output logic [CW-1:0]        o_count
);

    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_valid;
    div_entry_t       r_mem [DEPTH];

    // A killed entry keeps its slot; it is retired by a normal dequeue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && r_valid[i] && (r_mem[i].rd == i_kill_rd)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (i_deq) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= r_rptr + PW'(1);
            end
            if (i_enq) begin
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= r_wptr + PW'(1);
            end
            case ({i_enq, i_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_enq) begin
            r_mem[r_wptr] <= i_enq_data;
        end
    end

    assign o_head_valid = r_valid[r_rptr];
    assign o_head_data  = r_mem[r_rptr];
    assign o_empty      = (r_count == '0);
    assign o_count      = r_count;

endmodule : div_result_queue
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Merges pipeline and divider results onto the register-file
//               write port, queueing colliding divider results in order.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = DIV_WB_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  wb
);

    exe_wb_inf_t          w_pipe;
    exe_wb_inf_t          w_div;
    logic                 w_pipe_req;
    logic                 w_div_arrive;
    logic                 w_div_req;
    logic                 w_bypass;
    logic                 w_enq;
    logic                 w_deq;
    logic                 w_deq_wr;
    logic                 w_q_full;
    logic                 w_ovf_set;
    logic                 w_head_valid;
    div_entry_t           w_head_data;
    logic                 w_q_empty;
    logic [CW-1:0]        w_count;

    logic                 r_rf_we;
    logic [REG_WIDTH-1:0] r_rf_rd;
    logic [31:0]          r_rf_wdata;
    logic                 r_overflow;

    assign w_pipe = wb.pipe_wb_inf;
    assign w_div  = wb.div_wb_inf;

    assign w_pipe_req   = w_pipe.instruction_valid & w_pipe.register_write
                        & ~wb.stall & (w_pipe.rd != '0);
    assign w_div_arrive = w_div.instruction_valid & w_div.register_write
                        & (w_div.rd != '0) & ~wb.flush;
    // A divider result aimed at the same rd as a concurrent pipeline write is stale.
    assign w_div_req    = w_div_arrive & ~(w_pipe_req & (w_div.rd == w_pipe.rd));

    assign w_q_full  = (w_count == CW'(DEPTH));
    assign w_bypass  = w_div_req & ~w_pipe_req & w_q_empty;
    assign w_enq     = w_div_req & ~w_bypass & ~w_q_full;
    assign w_ovf_set = w_div_req & ~w_bypass & w_q_full;
    assign w_deq     = ~w_q_empty & ~w_pipe_req & ~wb.flush;
    assign w_deq_wr  = w_deq & w_head_valid;

    div_result_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (wb.flush),
        .i_enq        (w_enq),
        .i_enq_data   ({w_div.rd, w_div.exe_result}),
        .i_deq        (w_deq),
        .i_kill       (w_pipe_req),
        .i_kill_rd    (w_pipe.rd),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data),
        .o_empty      (w_q_empty),
        .o_count      (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_wdata <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rf_we <= w_pipe_req | w_bypass | w_deq_wr;
            if (w_pipe_req) begin
                r_rf_rd    <= w_pipe.rd;
                r_rf_wdata <= w_pipe.exe_result;
            end else if (w_bypass) begin
                r_rf_rd    <= w_div.rd;
                r_rf_wdata <= w_div.exe_result;
            end else if (w_deq_wr) begin
                r_rf_rd    <= w_head_data.rd;
                r_rf_wdata <= w_head_data.data;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign wb.rf_we           = r_rf_we;
    assign wb.rf_rd           = r_rf_rd;
    assign wb.rf_wdata        = r_rf_wdata;
    assign wb.div_wb_full     = (w_count >= CW'(DEPTH - 1));
    assign wb.div_wb_overflow = r_overflow;

endmodule : wb_arbiter
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Scoreboard bench for wb_arbiter against a queue-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = DIV_WB_DEPTH;

    typedef struct {
        logic [REG_WIDTH-1:0] rd;
        logic [31:0]          data;
        bit                   live;
    } m_ent_t;

    typedef struct {
        int                   cyc;
        logic [REG_WIDTH-1:0] rd;
        logic [31:0]          data;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    m_ent_t mq[$];
    exp_t   expq[$];
    bit     m_ovf;
    bit     mon_en;
    int     cyc;
    int     n_chk;
    int     n_pass;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic exe_wb_inf_t mk(input bit v, input bit rw, input int rd, input logic [31:0] d);
        exe_wb_inf_t r;
        r.instruction_valid = v;
        r.register_write    = rw;
        r.rd                = REG_WIDTH'(rd);
        r.exe_result        = d;
        return r;
    endfunction

    // Applies one cycle of stimulus and advances the reference model by that cycle.
    task automatic drive(input bit st, input bit fl, input exe_wb_inf_t p, input exe_wb_inf_t d);
        bit                   preq;
        bit                   dreq;
        bit                   wr;
        int                   pre;
        logic [REG_WIDTH-1:0] wrd;
        logic [31:0]          wdat;
        m_ent_t               h;
        bus.stall       = st;
        bus.flush       = fl;
        bus.pipe_wb_inf = p;
        bus.div_wb_inf  = d;
        preq = p.instruction_valid && p.register_write && !st && (p.rd != 0);
        dreq = d.instruction_valid && d.register_write && (d.rd != 0) && !fl;
        pre  = mq.size();
        wr   = 1'b0;
        wrd  = '0;
        wdat = '0;
        if (preq) begin
            wr = 1'b1; wrd = p.rd; wdat = p.exe_result;
            foreach (mq[i]) if (mq[i].rd == p.rd) mq[i].live = 1'b0;
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (!preq && pre > 0) begin
                h = mq.pop_front();
                if (h.live) begin wr = 1'b1; wrd = h.rd; wdat = h.data; end
            end
            if (dreq && !(preq && d.rd == p.rd)) begin
                if (pre == 0 && !preq) begin
                    wr = 1'b1; wrd = d.rd; wdat = d.exe_result;
                end else if (pre == DEPTH) begin
                    m_ovf = 1'b1;
                end else begin
                    mq.push_back('{d.rd, d.exe_result, 1'b1});
                end
            end
        end
        if (wr) expq.push_back('{cyc + 1, wrd, wdat});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    endtask

    always begin : monitor
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (bus.rf_we) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write (cycle %0d)",
                             bus.rf_rd, bus.rf_wdata, cyc);
                end else begin
                    e = expq.pop_front();
                    chk("write_cycle", cyc, e.cyc);
                    chk("write_rd", 32'(bus.rf_rd), 32'(e.rd));
                    chk("write_data", bus.rf_wdata, e.data);
                end
            end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
                n_chk++;
                $display("FAIL missing_write: got no write expected rd=%0d data=%0h (cycle %0d)",
                         expq[0].rd, expq[0].data, cyc);
                void'(expq.pop_front());
            end
            chk("div_wb_full", 32'(bus.div_wb_full), 32'(mq.size() >= DEPTH - 1));
            chk("div_wb_overflow", 32'(bus.div_wb_overflow), 32'(m_ovf));
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_rf_we"}, 32'(bus.rf_we), 0);
        chk({tag, "_rf_rd"}, 32'(bus.rf_rd), 0);
        chk({tag, "_rf_wdata"}, bus.rf_wdata, 0);
        chk({tag, "_full"}, 32'(bus.div_wb_full), 0);
        chk({tag, "_overflow"}, 32'(bus.div_wb_overflow), 0);
    endtask

    initial begin
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
        bus.pipe_wb_inf = '0;
        bus.div_wb_inf  = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Bypass
        drive(0, 0, mk(0, 0, 0, 0), mk(1, 1, 5, 32'h7));
        idle(2);
        // Collision
        drive(0, 0, mk(1, 1, 3, 32'h11), mk(1, 1, 4, 32'h22));
        idle(3);
        // WAW kill
        drive(0, 0, mk(1, 1, 2, 32'h1), mk(1, 1, 7, 32'hAA));
        drive(0, 0, mk(1, 1, 7, 32'hBB), mk(0, 0, 0, 0));
        idle(3);
        // Stall drain
        drive(0, 0, mk(1, 1, 1, 32'h2), mk(1, 1, 9, 32'h55));
        drive(1, 0, mk(1, 1, 10, 32'h77), mk(0, 0, 0, 0));
        idle(2);
        // Flush and x0
        drive(0, 0, mk(1, 1, 1, 32'h3), mk(1, 1, 12, 32'h66));
        drive(0, 1, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
        idle(2);
        drive(0, 0, mk(0, 0, 0, 0), mk(1, 1, 0, 32'h99));
        idle(2);
        // Overflow then asynchronous reset with the queue occupied
        for (int i = 0; i <= DEPTH; i++)
            drive(0, 0, mk(1, 1, 1, 32'h40 + i), mk(1, 1, 20 + i, 32'h80 + i));
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_zero("async_reset");
        mq.delete();
        expq.delete();
        m_ovf = 1'b0;
        bus.pipe_wb_inf = '0;
        bus.div_wb_inf  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        for (int n = 0; n < 800; n++) begin
            bit st;
            bit fl;
            bit dv;
            st = ($urandom_range(3) == 0);
            fl = ($urandom_range(19) == 0);
            dv = ($urandom_range(2) == 0) && (mq.size() < DEPTH - 1);
            drive(st, fl,
                  mk($urandom_range(1), $urandom_range(7) != 0, $urandom_range(7), $urandom),
                  mk(dv, $urandom_range(7) != 0, $urandom_range(7), $urandom));
        end
        idle(4);
        chk("expected_drained", 32'(expq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_wb_arbiter
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute units and the register-file write port. Merges the in-order pipeline result (ALU/MUL/LSU path, stall-governed) with the out-of-pipeline divider result (`div_wb_inf`, a one-cycle pulse that ignores stall). Divider results that collide with a pipeline write are held in a small queue. It preserves write-after-write order and back-pressures the dispatcher so no divider result is lost.

## Interface
- `DEPTH`, default 2: divider-result queue entries; must be a power of two and at least 2.
- `clk`  in  1  single core clock; all state is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state.
- `stall`  in  1  core stall; when high, `pipe_wb_inf` is not consumed.
- `flush`  in  1  core flush; squashes divider results.
- `pipe_wb_inf`  in  `exe_wb_inf_t`  in-pipeline result: `instruction_valid`, `register_write`, `rd`, `exe_result`.
- `div_wb_inf`  in  `exe_wb_inf_t`  divider result; `instruction_valid` is a single-cycle pulse.
- `rf_we`  out  1  register-file write enable (registered).
- `rf_rd`  out  REG_WIDTH  write address (registered).
- `rf_wdata`  out  32  write data (registered).
- `div_wb_full`  out  1  queue holds `DEPTH-1` or more entries; the dispatcher must not issue a DIV while it is high.
- `div_wb_overflow`  out  1  sticky error; set when a divider result arrives while the queue is full.

## Operation
- **Qualified requests**
  - `pipe_req` = `pipe_wb_inf.instruction_valid & register_write & !stall & (rd != 0)`.
  - `div_req` = `div_wb_inf.instruction_valid & register_write & (rd != 0) & !flush`.
  - Writes to x0 are discarded on both paths.
- **Priority**: `pipe_req` always wins the write port and is never delayed.
- **Divider path, queue empty**
  - `div_req` with no `pipe_req`: the result bypasses straight to the write port.
  - `div_req` with `pipe_req`: the result is enqueued.
- **Divider path, queue not empty**
  - A new `div_req` is enqueued at the tail.
  - If there is no `pipe_req`, the head is dequeued and written in the same cycle. Queue order is strictly FIFO.
- **WAW kill**: any queued entry whose `rd` equals the `rd` of a `pipe_req` in the same cycle is invalidated (valid bit cleared, slot still occupied). The younger pipeline write must win.
  - An arriving `div_req` whose `rd` matches a simultaneous `pipe_req` is dropped, not enqueued.
  - Dequeuing an invalid head consumes the slot and produces no write (`rf_we` = 0 that cycle).
- **Flush**
  - Clears all queue entries and the count.
  - `div_wb_inf` in the flush cycle is discarded.
  - A `pipe_req` in the flush cycle is still written.
- **Stall**: only masks `pipe_req`. The queue keeps draining during stall.
- **Queue full**: a `div_req` arriving while full is dropped and sets `div_wb_overflow`. The flag clears only on reset.

## Timing
- Latency is one cycle from a qualified input to `rf_we`/`rf_rd`/`rf_wdata`. Queued entries write at least two cycles after arrival.
- Reset values: `rf_we`=0, `rf_rd`=0, `rf_wdata`=0, `div_wb_full`=0, `div_wb_overflow`=0, queue empty with read/write pointers at 0.
- Asserting reset mid-operation empties the queue immediately; in-flight results are lost.
- **Queue count**
  - Count width is `$clog2(DEPTH)+1`.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
  - Simultaneous enqueue and dequeue leaves the count unchanged.
- `div_wb_full` is combinational from the count, valid in the same cycle.

## Structure
- `exe_wb_inf_t` and `REG_WIDTH` already live in the shared package. Add `DIV_WB_DEPTH` = 2 to the same package.
- One sub-module: `div_result_queue`.
  - Circular buffer with per-entry valid bits and an `rd` compare-and-kill port.
  - Outputs: `head_valid`, `head_data`, `empty`, `count`.
- The arbitration mux and output registers live in `wb_arbiter`.

## Test plan
- **Bypass**: idle pipeline, div result rd=5 data=0x0000_0007 → next cycle `rf_we`=1, `rf_rd`=5, `rf_wdata`=7. The queue stays empty.
- **Collision**: pipe rd=3 data=0x11 and div rd=4 data=0x22 in the same cycle → cycle+1 writes rd3=0x11; cycle+2 writes rd4=0x22.
- **WAW kill**: div rd=7 data=0xAA queued behind pipe rd=2, then pipe rd=7 data=0xBB the next cycle → only 0xBB is written to rd7. The queue empties with no 0xAA write.
- **Stall drain**: queue holds rd=9 data=0x55, `stall`=1 with a valid pipe input → rd9=0x55 is written and the pipe input is not written.
- **Flush and x0**: queue holds one entry, then `flush`=1 → no divider write follows and count is 0. A div result with rd=0 never asserts `rf_we`.
- **Overflow and reset**: force DEPTH+1 collided div results → `div_wb_full` is high at count 1 and `div_wb_overflow` latches. Asserting `rst`=0 asynchronously mid-queue clears all outputs to 0 in the same cycle.
